nn_sequencer: RTL

Controller that sequences the O/X classifier (mlp_OX) for inference and on-line training.
- Detects submit and label-button presses and waits for the input flags to settle.
- Waits the classifier latency, then latches the O/X decision and probability.
- Optionally drives a learn pulse with the ground-truth label.
- Keeps train/accuracy statistics and drives the result LED pattern.
Sits in top between input_manager/mlp_OX and the LED outputs, replacing the ad-hoc submit/LED logic there.

---
 rtl/nn_sequencer_pkg.sv | 44 ++++
 rtl/nn_sequencer_if.sv | 10 +
 rtl/nn_sequencer_btn_edge.sv | 20 ++
 rtl/nn_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/nn_sequencer_pkg.sv
// Shared types and constants for the O/X classifier sequencer: FSM states,
// operation kinds, probability clamp and LED bar thresholds.
package nn_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_INFER,
    S_LATCH,
    S_LABEL,
    S_LEARN,
    S_HOLD
  } state_t;

  typedef enum logic {
    OP_INFER,
    OP_TRAIN
  } op_t;

  localparam logic [6:0] PROB_MAX = 7'd100;

  localparam logic [6:0] BAR_T6 = 7'd85;
  localparam logic [6:0] BAR_T5 = 7'd71;
  localparam logic [6:0] BAR_T4 = 7'd57;
  localparam logic [6:0] BAR_T3 = 7'd43;
  localparam logic [6:0] BAR_T2 = 7'd29;
  localparam logic [6:0] BAR_T1 = 7'd15;

  function automatic logic [6:0] clamp_prob(input logic [6:0] p);
    return (p > PROB_MAX) ? PROB_MAX : p;
  endfunction

  // Thermometer bar; always at least one segment lit for a valid result.
  function automatic logic [6:0] led_bar(input logic [6:0] p);
    if (p >= BAR_T6)      return 7'h7F;
    else if (p >= BAR_T5) return 7'h3F;
    else if (p >= BAR_T4) return 7'h1F;
    else if (p >= BAR_T3) return 7'h0F;
    else if (p >= BAR_T2) return 7'h07;
    else if (p >= BAR_T1) return 7'h03;
    else                  return 7'h01;
  endfunction

endpackage

// File: rtl/nn_sequencer_if.sv
// Sequencer <-> mlp_OX classifier link: decision/probability in, learn/label out.
interface nn_sequencer_if;
  logic       nn_y;
  logic [6:0] nn_o_prob_pct;
  logic       nn_learn;
  logic       nn_is_O;

  modport master (input nn_y, nn_o_prob_pct, output nn_learn, nn_is_O);
  modport slave  (output nn_y, nn_o_prob_pct, input nn_learn, nn_is_O);
endinterface

// File: rtl/nn_sequencer_btn_edge.sv
// Parameterized rising-edge detector; one history flop per input bit.
module btn_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/nn_sequencer.sv
// Sequences mlp_OX for inference and on-line training, latches the result,
// keeps training statistics and drives the result LED pattern.
module nn_sequencer
  import nn_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned INFER_LAT  = 2,
  parameter int unsigned LEARN_CYC  = 1,
  parameter int unsigned HOLD_CYC   = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_submit,
  input  logic                  btn_train_o,
  input  logic                  btn_train_x,
  input  logic [3:0]            input_count,
  nn_sequencer_if.master        nn_bus,
  output logic                  busy,
  output logic                  result_valid,
  output logic                  result_is_O,
  output logic [6:0]            result_prob,
  output logic [7:0]            led,
  output logic                  reject,
  output logic [7:0]            train_cnt,
  output logic [7:0]            correct_cnt
);

  localparam int unsigned M1   = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
  localparam int unsigned M2   = (INFER_LAT > LEARN_CYC) ? INFER_LAT : LEARN_CYC;
  localparam int unsigned MAXC = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_SETTLE = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [CW-1:0] LD_INFER  = CW'((INFER_LAT  > 0) ? INFER_LAT  - 1 : 0);
  localparam logic [CW-1:0] LD_LEARN  = CW'((LEARN_CYC  > 0) ? LEARN_CYC  - 1 : 0);
  localparam logic [CW-1:0] LD_HOLD   = CW'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, ld;
  logic [2:0]    rise;
  op_t           op;
  logic          label;
  logic          is_o_q;
  logic          req_any, accept, rej;

  btn_edge #(.W(3)) u_btn_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({btn_train_x, btn_train_o, btn_submit}),
    .rise (rise)
  );

  // Submit wins; simultaneous train_o/train_x without submit is no request at all.
  always_comb begin
    req_any = 1'b0;
    accept  = 1'b0;
    rej     = 1'b0;
    if (state == S_IDLE || state == S_HOLD)
      req_any = rise[0] | (rise[1] ^ rise[2]);
    accept  = req_any && (input_count != 4'd0);
    rej     = req_any && (input_count == 4'd0);

    state_n = state;
    unique case (state)
      S_IDLE:   if (accept) state_n = S_SETTLE;
      S_SETTLE: if (cnt == '0) state_n = S_INFER;
      S_INFER:  if (cnt == '0) state_n = S_LATCH;
      S_LATCH:  state_n = (op == OP_TRAIN) ? S_LABEL : S_HOLD;
      S_LABEL:  state_n = S_LEARN;
      S_LEARN:  if (cnt == '0) state_n = S_HOLD;
      S_HOLD: begin
        if (accept)                              state_n = S_SETTLE;
        else if (HOLD_CYC != 0 && cnt == '0)     state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase

    ld = '0;
    unique case (state_n)
      S_SETTLE: ld = LD_SETTLE;
      S_INFER:  ld = LD_INFER;
      S_LEARN:  ld = LD_LEARN;
      S_HOLD:   ld = LD_HOLD;
      default:  ld = '0;
    endcase

    if (state_n != state)  cnt_n = ld;
    else if (cnt != '0)    cnt_n = cnt - 1'b1;
    else                   cnt_n = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op           <= OP_INFER;
      label        <= 1'b0;
      is_o_q       <= 1'b0;
      result_valid <= 1'b0;
      result_is_O  <= 1'b0;
      result_prob  <= '0;
      reject       <= 1'b0;
      train_cnt    <= '0;
      correct_cnt  <= '0;
    end else begin
      reject <= rej;
      if (accept) begin
        result_valid <= 1'b0;
        op           <= rise[0] ? OP_INFER : OP_TRAIN;
        label        <= rise[1];
      end
      if (state == S_LATCH) begin
        result_valid <= 1'b1;
        result_is_O  <= nn_bus.nn_y;
        result_prob  <= clamp_prob(nn_bus.nn_o_prob_pct);
        if (op == OP_TRAIN) is_o_q <= label;
      end
      if (state == S_LABEL && result_is_O == label && correct_cnt != 8'hFF)
        correct_cnt <= correct_cnt + 8'd1;
      if (state == S_LEARN && cnt == '0 && train_cnt != 8'hFF)
        train_cnt <= train_cnt + 8'd1;
      if (state == S_HOLD && state_n == S_IDLE)
        result_valid <= 1'b0;
    end
  end

  assign busy            = (state != S_IDLE);
  assign led             = result_valid ? {result_is_O, led_bar(result_prob)} : '0;
  assign nn_bus.nn_learn = (state == S_LEARN);
  assign nn_bus.nn_is_O  = is_o_q;

endmodule
